// File: rtl/pll_lock_reset_ctrl.sv
// PLL bring-up sequencer: pulses the PLL reset, waits for a stable lock with bounded retries,
// then releases the downstream system reset and re-sequences on lock loss.
module pll_lock_reset_ctrl #(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT  = 50000,
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned MAX_RETRIES   = 3
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       clear_fault,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       ready,
  output logic       fault,
  output logic [3:0] retry_cnt,
  output logic [7:0] lock_loss_cnt
);

  localparam int unsigned MaxRstTo = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int unsigned MaxParam = (MaxRstTo > STABLE_CYCLES) ? MaxRstTo : STABLE_CYCLES;
  localparam int unsigned CntW     = $clog2(MaxParam) + 1;

  localparam logic [CntW-1:0] CntMax     = '1;
  localparam logic [CntW-1:0] RstLast    = CntW'(RST_CYCLES - 1);
  localparam logic [CntW-1:0] ToLast     = CntW'(LOCK_TIMEOUT - 1);
  localparam logic [CntW-1:0] StableLast = CntW'(STABLE_CYCLES - 1);
  localparam logic [3:0]      MaxRetry   = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    StResetPll,
    StWaitLock,
    StStable,
    StRun,
    StFault
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q;
  logic            sync_q, locked_s;
  logic [3:0]      retry_d;
  logic [7:0]      loss_d;

  always_comb begin
    state_d = state_q;
    retry_d = retry_cnt;
    loss_d  = lock_loss_cnt;
    unique case (state_q)
      StResetPll: begin
        if (cnt_q == RstLast) state_d = StWaitLock;
      end
      StWaitLock: begin
        // A lock seen on the timeout cycle still counts as a successful attempt.
        if (locked_s) begin
          state_d = StStable;
        end else if (cnt_q == ToLast) begin
          retry_d = retry_cnt + 4'd1;
          state_d = (retry_d == MaxRetry) ? StFault : StResetPll;
        end
      end
      StStable: begin
        if (!locked_s) begin
          state_d = StWaitLock;
        end else if (cnt_q == StableLast) begin
          state_d = StRun;
          retry_d = '0;
        end
      end
      StRun: begin
        if (!locked_s) begin
          state_d = StResetPll;
          if (lock_loss_cnt != 8'hff) loss_d = lock_loss_cnt + 8'd1;
        end
      end
      StFault: begin
        if (clear_fault) begin
          state_d = StResetPll;
          retry_d = '0;
        end
      end
      default: state_d = StResetPll;
    endcase
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      sync_q        <= 1'b0;
      locked_s      <= 1'b0;
      state_q       <= StResetPll;
      cnt_q         <= '0;
      retry_cnt     <= '0;
      lock_loss_cnt <= '0;
      pll_rst       <= 1'b1;
      sys_rst       <= 1'b1;
      ready         <= 1'b0;
      fault         <= 1'b0;
    end else begin
      sync_q        <= pll_locked;
      locked_s      <= sync_q;
      state_q       <= state_d;
      retry_cnt     <= retry_d;
      lock_loss_cnt <= loss_d;
      if (state_d != state_q) begin
        cnt_q <= '0;
      end else if (cnt_q != CntMax) begin
        cnt_q <= cnt_q + CntW'(1);
      end
      // Outputs follow the next state so they update together with the state register.
      pll_rst <= (state_d == StResetPll) || (state_d == StFault);
      sys_rst <= (state_d != StRun);
      ready   <= (state_d == StRun);
      fault   <= (state_d == StFault);
    end
  end

endmodule

// File: tb/tb_pll_lock_reset_ctrl.sv
// Bench for pll_lock_reset_ctrl: directed scenarios plus random lock/clear/reset traffic,
// all compared cycle by cycle against a phase/elapsed-time model of the sequencer.
module tb_pll_lock_reset_ctrl;

  localparam int unsigned RC = 4;
  localparam int unsigned TO = 20;
  localparam int unsigned SC = 8;
  localparam int unsigned MR = 2;

  logic       refclk = 1'b0;
  logic       rst = 1'b1;
  logic       pll_locked = 1'b0;
  logic       clear_fault = 1'b0;
  logic       pll_rst, sys_rst, ready, fault;
  logic [3:0] retry_cnt;
  logic [7:0] lock_loss_cnt;

  int checks = 0;
  int failures = 0;

  pll_lock_reset_ctrl #(
    .RST_CYCLES   (RC),
    .LOCK_TIMEOUT (TO),
    .STABLE_CYCLES(SC),
    .MAX_RETRIES  (MR)
  ) dut (
    .refclk       (refclk),
    .rst          (rst),
    .pll_locked   (pll_locked),
    .clear_fault  (clear_fault),
    .pll_rst      (pll_rst),
    .sys_rst      (sys_rst),
    .ready        (ready),
    .fault        (fault),
    .retry_cnt    (retry_cnt),
    .lock_loss_cnt(lock_loss_cnt)
  );

  always #5 refclk = ~refclk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference model: a phase plus its entry edge; synchronised lock is read from input history.
  typedef enum int {MReset, MWait, MStable, MRun, MFault} mphase_e;
  mphase_e ph = MReset;
  int      ent = 0;
  int      k_now = 0;
  int      last_rst = -10;
  int      m_retry = 0;
  int      m_loss = 0;
  bit      lk_hist[$];

  logic [15:0] dut_vec;
  assign dut_vec = {pll_rst, sys_rst, ready, fault, retry_cnt, lock_loss_cnt};

  function automatic logic [15:0] exp_vec();
    logic pr;
    pr = (ph == MReset) || (ph == MFault);
    return {pr, ph != MRun, ph == MRun, ph == MFault, 4'(m_retry), 8'(m_loss)};
  endfunction

  function automatic void enter(mphase_e p);
    ph  = p;
    ent = k_now;
  endfunction

  task automatic tick();
    int d;
    bit lks;
    @(posedge refclk);
    lk_hist.push_back(pll_locked);
    k_now = lk_hist.size() - 1;
    lks = (k_now >= 2 && last_rst < k_now - 2) ? lk_hist[k_now-2] : 1'b0;
    if (rst) begin
      ph = MReset; ent = k_now; m_retry = 0; m_loss = 0; last_rst = k_now;
    end else begin
      d = k_now - ent;
      case (ph)
        MReset:  if (d == RC) enter(MWait);
        MWait: begin
          if (lks) enter(MStable);
          else if (d == TO) begin
            m_retry++;
            enter((m_retry == MR) ? MFault : MReset);
          end
        end
        MStable: begin
          if (!lks) enter(MWait);
          else if (d == SC) begin m_retry = 0; enter(MRun); end
        end
        MRun: begin
          if (!lks) begin
            if (m_loss < 255) m_loss++;
            enter(MReset);
          end
        end
        MFault:  if (clear_fault) begin m_retry = 0; enter(MReset); end
        default: ;
      endcase
    end
    #1;
  endtask

  task automatic test_reset();
    pll_locked = 0; clear_fault = 0; rst = 1;
    tick(); tick();
    checks++;
    if (dut_vec !== 16'hC000) begin
      failures++; $display("FAIL reset_values got=%h exp=%h", dut_vec, 16'hC000);
    end
    checks++;
    if (dut_vec !== exp_vec()) begin
      failures++; $display("FAIL reset_model got=%h exp=%h", dut_vec, exp_vec());
    end
    rst = 0;
  endtask

  task automatic test_clean_bringup();
    int n;
    pll_locked = 0; rst = 1; tick(); rst = 0;
    n = 0;
    while (pll_rst === 1'b1 && n < 50) begin
      n++; tick(); checks++;
      if (dut_vec !== exp_vec()) begin
        failures++; $display("FAIL bringup_model k=%0d got=%h exp=%h", k_now, dut_vec, exp_vec());
      end
    end
    checks++;
    if (n != RC) begin failures++; $display("FAIL bringup_pll_rst_len got=%0d exp=%0d", n, RC); end
    repeat (4) begin
      tick(); checks++;
      if (dut_vec !== exp_vec()) begin
        failures++; $display("FAIL bringup_model k=%0d got=%h exp=%h", k_now, dut_vec, exp_vec());
      end
    end
    pll_locked = 1;
    n = 0;
    while (ready !== 1'b1 && n < 100) begin
      tick(); n++; checks++;
      if (dut_vec !== exp_vec()) begin
        failures++; $display("FAIL bringup_model k=%0d got=%h exp=%h", k_now, dut_vec, exp_vec());
      end
    end
    checks++;
    if (n != 2 + SC + 1) begin
      failures++; $display("FAIL bringup_ready_latency got=%0d exp=%0d", n, 2 + SC + 1);
    end
    checks++;
    if (sys_rst !== 1'b0 || retry_cnt !== 4'd0) begin
      failures++; $display("FAIL bringup_run_outputs sys_rst=%b retry=%0d exp 0/0", sys_rst, retry_cnt);
    end
  endtask

  task automatic test_no_lock();
    int n;
    pll_locked = 0; rst = 1; tick(); rst = 0;
    for (int r = 1; r <= int'(MR); r++) begin
      n = 0;
      while (pll_rst === 1'b1 && n < 50) begin
        n++; tick(); checks++;
        if (dut_vec !== exp_vec()) begin
          failures++; $display("FAIL nolock_model k=%0d got=%h exp=%h", k_now, dut_vec, exp_vec());
        end
      end
      checks++;
      if (n != RC) begin failures++; $display("FAIL nolock_pulse got=%0d exp=%0d", n, RC); end
      n = 0;
      while (pll_rst === 1'b0 && n < 100) begin
        tick(); n++; checks++;
        if (dut_vec !== exp_vec()) begin
          failures++; $display("FAIL nolock_model k=%0d got=%h exp=%h", k_now, dut_vec, exp_vec());
        end
      end
      checks++;
      if (n != TO) begin failures++; $display("FAIL nolock_wait got=%0d exp=%0d", n, TO); end
      checks++;
      if (retry_cnt !== 4'(r)) begin
        failures++; $display("FAIL nolock_retry got=%0d exp=%0d", retry_cnt, r);
      end
    end
    checks++;
    if (fault !== 1'b1 || pll_rst !== 1'b1 || sys_rst !== 1'b1) begin
      failures++; $display("FAIL nolock_fault got f=%b pr=%b sr=%b exp 1/1/1", fault, pll_rst, sys_rst);
    end
    repeat (10) begin
      tick(); checks++;
      if (dut_vec !== exp_vec()) begin
        failures++; $display("FAIL nolock_model k=%0d got=%h exp=%h", k_now, dut_vec, exp_vec());
      end
    end
    checks++;
    if (fault !== 1'b1 || pll_rst !== 1'b1) begin
      failures++; $display("FAIL nolock_fault_hold got f=%b pr=%b exp 1/1", fault, pll_rst);
    end
    clear_fault = 1; tick(); clear_fault = 0;
    checks++;
    if (retry_cnt !== 4'd0 || fault !== 1'b0 || pll_rst !== 1'b1) begin
      failures++;
      $display("FAIL clear_fault_exit got r=%0d f=%b pr=%b exp 0/0/1", retry_cnt, fault, pll_rst);
    end
    n = 0;
    while (pll_rst === 1'b1 && n < 50) begin
      n++; tick(); checks++;
      if (dut_vec !== exp_vec()) begin
        failures++; $display("FAIL nolock_model k=%0d got=%h exp=%h", k_now, dut_vec, exp_vec());
      end
    end
    checks++;
    if (n != RC) begin failures++; $display("FAIL clear_fault_pulse got=%0d exp=%0d", n, RC); end
  endtask

  task automatic test_stable_glitch();
    int n;
    bit retry_seen;
    pll_locked = 0; rst = 1; tick(); rst = 0;
    n = 0;
    while (pll_rst === 1'b1 && n < 50) begin n++; tick(); end
    pll_locked = 1;
    repeat (5) begin
      tick(); checks++;
      if (dut_vec !== exp_vec()) begin
        failures++; $display("FAIL glitch_model k=%0d got=%h exp=%h", k_now, dut_vec, exp_vec());
      end
    end
    pll_locked = 0; tick(); pll_locked = 1;
    n = 0; retry_seen = 0;
    while (ready !== 1'b1 && n < 100) begin
      tick(); n++; checks++;
      if (retry_cnt !== 4'd0) retry_seen = 1;
      if (dut_vec !== exp_vec()) begin
        failures++; $display("FAIL glitch_model k=%0d got=%h exp=%h", k_now, dut_vec, exp_vec());
      end
    end
    checks++;
    if (n != 2 + SC + 1) begin
      failures++; $display("FAIL glitch_ready_latency got=%0d exp=%0d", n, 2 + SC + 1);
    end
    checks++;
    if (retry_seen) begin failures++; $display("FAIL glitch_retry got=nonzero exp=0"); end
  endtask

  task automatic test_run_loss();
    int n;
    pll_locked = 0;
    n = 0;
    while (sys_rst !== 1'b1 && n < 20) begin
      tick(); n++; checks++;
      if (dut_vec !== exp_vec()) begin
        failures++; $display("FAIL loss_model k=%0d got=%h exp=%h", k_now, dut_vec, exp_vec());
      end
    end
    checks++;
    if (n != 3) begin failures++; $display("FAIL loss_sys_rst_latency got=%0d exp=3", n); end
    checks++;
    if (ready !== 1'b0 || pll_rst !== 1'b1 || lock_loss_cnt !== 8'd1) begin
      failures++;
      $display("FAIL loss_outputs got rdy=%b pr=%b cnt=%0d exp 0/1/1", ready, pll_rst, lock_loss_cnt);
    end
    n = 0;
    while (pll_rst === 1'b1 && n < 50) begin n++; tick(); end
    checks++;
    if (n != RC) begin failures++; $display("FAIL loss_new_pulse got=%0d exp=%0d", n, RC); end
    repeat (255) begin
      pll_locked = 1; n = 0;
      while (ready !== 1'b1 && n < 100) begin
        tick(); n++; checks++;
        if (dut_vec !== exp_vec()) begin
          failures++; $display("FAIL loss_loop k=%0d got=%h exp=%h", k_now, dut_vec, exp_vec());
        end
      end
      pll_locked = 0; n = 0;
      while (sys_rst !== 1'b1 && n < 20) begin
        tick(); n++; checks++;
        if (dut_vec !== exp_vec()) begin
          failures++; $display("FAIL loss_loop k=%0d got=%h exp=%h", k_now, dut_vec, exp_vec());
        end
      end
    end
    checks++;
    if (lock_loss_cnt !== 8'd255) begin
      failures++; $display("FAIL loss_saturate got=%0d exp=255", lock_loss_cnt);
    end
  endtask

  task automatic test_reset_priority();
    int n;
    pll_locked = 1; n = 0;
    while (ready !== 1'b1 && n < 100) begin tick(); n++; end
    clear_fault = 1; tick(); clear_fault = 0;
    checks++;
    if (ready !== 1'b1 || fault !== 1'b0 || dut_vec !== exp_vec()) begin
      failures++; $display("FAIL clear_in_run_ignored got=%h exp=%h", dut_vec, exp_vec());
    end
    rst = 1; tick(); rst = 0;
    checks++;
    if (dut_vec !== 16'hC000) begin
      failures++; $display("FAIL rst_in_run got=%h exp=%h", dut_vec, 16'hC000);
    end
    tick(); tick();
    rst = 1; tick(); rst = 0;
    checks++;
    if (dut_vec !== 16'hC000) begin
      failures++; $display("FAIL rst_mid_pulse got=%h exp=%h", dut_vec, 16'hC000);
    end
    n = 0;
    while (pll_rst === 1'b1 && n < 50) begin
      n++; tick(); checks++;
      if (dut_vec !== exp_vec()) begin
        failures++; $display("FAIL prio_model k=%0d got=%h exp=%h", k_now, dut_vec, exp_vec());
      end
    end
    checks++;
    if (n != RC) begin failures++; $display("FAIL rst_mid_pulse_len got=%0d exp=%0d", n, RC); end
    pll_locked = 0; n = 0;
    while (fault !== 1'b1 && n < 300) begin tick(); n++; end
    checks++;
    if (fault !== 1'b1) begin failures++; $display("FAIL prio_reach_fault got=%b exp=1", fault); end
    rst = 1; clear_fault = 1; tick(); rst = 0; clear_fault = 0;
    checks++;
    if (dut_vec !== 16'hC000) begin
      failures++; $display("FAIL rst_in_fault got=%h exp=%h", dut_vec, 16'hC000);
    end
  endtask

  task automatic test_random();
    int run_left;
    run_left = 0;
    rst = 1; tick(); rst = 0;
    for (int i = 0; i < 4000; i++) begin
      if (run_left == 0) begin
        pll_locked = 1'($urandom_range(0, 1));
        run_left   = int'($urandom_range(1, 60));
      end
      run_left--;
      clear_fault = ($urandom_range(0, 15) == 0);
      rst         = ($urandom_range(0, 499) == 0);
      tick(); checks++;
      if (dut_vec !== exp_vec()) begin
        failures++; $display("FAIL random k=%0d got=%h exp=%h", k_now, dut_vec, exp_vec());
      end
    end
    rst = 0; clear_fault = 0;
  endtask

  initial begin
    test_reset();
    test_clean_bringup();
    test_no_lock();
    test_stable_glitch();
    test_run_loss();
    test_reset_priority();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pll_lock_reset_ctrl.md
PLL_LOCK_RESET_CTRL -- requirements
Module: pll_lock_reset_ctrl

Interface
REQ-001 Parameter RST_CYCLES, default 16: cycles pll_rst is held high per PLL reset pulse (>=1).
REQ-002 Parameter LOCK_TIMEOUT, default 50000: cycles allowed for lock after pll_rst release (1 ms at 50 MHz).
REQ-003 Parameter STABLE_CYCLES, default 1024: consecutive locked cycles required before release of sys_rst.
REQ-004 Parameter MAX_RETRIES, default 3: failed lock attempts before entering FAULT (1..15).
REQ-005 refclk  in  1  free-running reference clock, sole clock of the block.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 pll_locked  in  1  PLL locked indicator, asynchronous to refclk.
REQ-008 clear_fault  in  1  single-cycle request to leave FAULT.
REQ-009 pll_rst  out  1  drives the PLL rst input.
REQ-010 sys_rst  out  1  active-high reset for logic clocked by the PLL output.
REQ-011 ready  out  1  high only in RUN.
REQ-012 fault  out  1  high only in FAULT.
REQ-013 retry_cnt  out  4  failed lock attempts in the current bring-up.
REQ-014 lock_loss_cnt  out  8  lock losses seen in RUN, saturating.

Function
REQ-015 pll_locked SHALL pass a 2-flop synchronizer; the FSM sees locked_s, 2 cycles after pll_locked changes.
REQ-016 All outputs SHALL be registered; they change on the cycle after the state transition that causes the change.
REQ-017 FSM states SHALL be RESET_PLL, WAIT_LOCK, STABLE, RUN and FAULT; one cycle counter, cleared on every state entry.
REQ-018 RESET_PLL: pll_rst=1, sys_rst=1; after RST_CYCLES cycles -> WAIT_LOCK.
REQ-019 WAIT_LOCK: pll_rst=0, sys_rst=1; locked_s=1 -> STABLE.
REQ-020 WAIT_LOCK: when the counter reaches LOCK_TIMEOUT without lock, retry_cnt SHALL increment.
REQ-021 On that timeout: new retry_cnt==MAX_RETRIES -> FAULT, otherwise -> RESET_PLL.
REQ-022 STABLE: pll_rst=0, sys_rst=1; locked_s=0 -> WAIT_LOCK with the timeout restarted and no retry increment.
REQ-023 STABLE: after STABLE_CYCLES consecutive locked_s=1 cycles -> RUN, and retry_cnt is cleared.
REQ-024 RUN: sys_rst=0, ready=1, pll_rst=0.
REQ-025 RUN: locked_s=0 -> RESET_PLL, with lock_loss_cnt incremented (saturates at 255) and sys_rst reasserted on the next cycle.
REQ-026 FAULT: pll_rst=1, sys_rst=1, fault=1; clear_fault=1 -> RESET_PLL with retry_cnt cleared.
REQ-027 clear_fault SHALL be ignored in every state other than FAULT.
REQ-028 Timeout and lock in the same WAIT_LOCK cycle: lock wins (-> STABLE, no increment).
REQ-029 Counter widths SHALL be $clog2 of the largest parameter plus 1; counters SHALL never wrap.

Reset
REQ-030 rst=1 SHALL force, on the next refclk edge, all of the following:
- state RESET_PLL, pll_rst=1, sys_rst=1;
- ready=0, fault=0;
- retry_cnt=0, lock_loss_cnt=0, cycle counter=0;
- synchronizer flops=0.
REQ-031 rst SHALL take priority over all other inputs in every state, including mid-pulse and FAULT.
REQ-032 After rst deasserts, a full RST_CYCLES pulse SHALL be issued before WAIT_LOCK.

Verification (RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRIES=2)
REQ-033 Clean bring-up: release rst; pll_locked=1 from 5 cycles after pll_rst falls.
- pll_rst high for 4 cycles after rst release;
- ready=1 and sys_rst=0 exactly 2+8 (+register) cycles after pll_locked rises;
- retry_cnt=0.
REQ-034 Lock never arrives:
- two 4-cycle pll_rst pulses, each followed by a 20-cycle wait;
- retry_cnt steps to 1 then 2, then fault=1 with pll_rst held high;
- clear_fault -> retry_cnt=0 and a new pll_rst pulse.
REQ-035 Lock glitch in STABLE: pll_locked low for 1 cycle after 5 locked cycles.
- FSM returns to WAIT_LOCK and retry_cnt stays 0;
- ready only after 8 fresh consecutive locked cycles.
REQ-036 Lock loss in RUN: drop pll_locked.
- sys_rst=1 and ready=0 within 4 cycles;
- lock_loss_cnt 0->1, then a new pll_rst pulse;
- 256 repeated losses leave lock_loss_cnt=255.
REQ-037 Reset priority:
- rst asserted during RUN and during FAULT -> all reset values on the next edge;
- clear_fault pulsed in RUN -> no effect.
